bit_stream_serializer: RTL and testbench

//  Parallel-to-serial front end for the sequence detectors. Accepts DATA_W-bit words
//  on a valid/ready handshake and emits one bit per clock on serial output a.
//  a is registered and drives the detector's a input directly.
//  a_valid marks cycles that carry payload bits; a is forced to 0 when a_valid=0.

---
 rtl/seq_det_pkg.sv | 16 +
 rtl/bit_stream_serializer.sv | 116 +++++++++++
 tb/tb_bit_stream_serializer.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/seq_det_pkg.sv
// Shared definitions for the sequence-detector front end.
package seq_det_pkg;

    // Default serializer word width
    localparam int unsigned SER_DATA_W = 8;

    // Serializer state encoding
    localparam logic SER_IDLE  = 1'b0;
    localparam logic SER_SHIFT = 1'b1;

    typedef enum logic {
        ST_IDLE  = SER_IDLE,
        ST_SHIFT = SER_SHIFT
    } ser_state_e;

endpackage : seq_det_pkg

// File: rtl/bit_stream_serializer.sv
// Parallel-to-serial front end: takes words on valid/ready, emits one bit per clock.
// The next word can be taken in the last-bit cycle, so consecutive words stream with no gap.
module bit_stream_serializer
    import seq_det_pkg::*;
#(
    parameter int unsigned DATA_W    = SER_DATA_W,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] din,
    input  logic              din_valid,
    output logic              din_ready,
    output logic              a,
    output logic              a_valid,
    output logic              busy
);

    localparam int unsigned     CNT_W    = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

    ser_state_e        state_q, state_d;
    logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic [DATA_W-1:0] sreg_q, sreg_d;
    logic              a_q, a_d;
    logic              a_valid_q, a_valid_d;
    logic              busy_q, busy_d;
    logic              hs;

    // Bit that leaves the word first in the configured order
    function automatic logic first_bit(input logic [DATA_W-1:0] w);
        return MSB_FIRST ? w[DATA_W-1] : w[0];
    endfunction

    // Word with the outgoing bit removed
    function automatic logic [DATA_W-1:0] shift_out(input logic [DATA_W-1:0] w);
        return MSB_FIRST ? (w << 1) : (w >> 1);
    endfunction

    // Ready in idle or while the last bit of the current word is on a
    always_comb begin
        din_ready = (state_q == ST_IDLE) || (bit_cnt_q == CNT_LAST);
        hs        = din_valid && din_ready;
    end

    // Next-state, counter, shift register and output decode
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        sreg_d    = sreg_q;
        a_d       = 1'b0;
        a_valid_d = 1'b0;
        busy_d    = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (hs) begin
                    state_d   = ST_SHIFT;
                    bit_cnt_d = '0;
                    a_d       = first_bit(din);
                    sreg_d    = shift_out(din);
                    a_valid_d = 1'b1;
                    busy_d    = 1'b1;
                end
            end
            ST_SHIFT: begin
                if (bit_cnt_q == CNT_LAST) begin
                    if (hs) begin
                        bit_cnt_d = '0;
                        a_d       = first_bit(din);
                        sreg_d    = shift_out(din);
                        a_valid_d = 1'b1;
                        busy_d    = 1'b1;
                    end else begin
                        state_d   = ST_IDLE;
                        bit_cnt_d = '0;
                    end
                end else begin
                    bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    a_d       = first_bit(sreg_q);
                    sreg_d    = shift_out(sreg_q);
                    a_valid_d = 1'b1;
                    busy_d    = 1'b1;
                end
            end
            default: begin
                state_d   = ST_IDLE;
                bit_cnt_d = '0;
            end
        endcase
    end

    // State and datapath registers; reset discards any word in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            bit_cnt_q <= '0;
            sreg_q    <= '0;
            a_q       <= 1'b0;
            a_valid_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            sreg_q    <= sreg_d;
            a_q       <= a_d;
            a_valid_q <= a_valid_d;
            busy_q    <= busy_d;
        end
    end

    assign a       = a_q;
    assign a_valid = a_valid_q;
    assign busy    = busy_q;

endmodule : bit_stream_serializer

// File: tb/tb_bit_stream_serializer.sv
// Bench for bit_stream_serializer: MSB-first and LSB-first instances share one stimulus
// stream; a queue scoreboard predicts every output cycle.
module tb_bit_stream_serializer;

    localparam int unsigned W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] din;
    logic         din_valid;

    logic rdy_m, a_m, av_m, busy_m;
    logic rdy_l, a_l, av_l, busy_l;

    int n_checks = 0;
    int n_errors = 0;

    logic q_msb[$];
    logic q_lsb[$];
    logic exp_a_m, exp_a_l, exp_valid;
    logic hs_seen;
    logic chk_en = 1'b0;
    int   n_valid_m = 0;
    int   n_valid_l = 0;

    bit_stream_serializer #(.DATA_W(W), .MSB_FIRST(1'b1)) u_msb (
        .clk(clk), .rst(rst), .din(din), .din_valid(din_valid),
        .din_ready(rdy_m), .a(a_m), .a_valid(av_m), .busy(busy_m)
    );

    bit_stream_serializer #(.DATA_W(W), .MSB_FIRST(1'b0)) u_lsb (
        .clk(clk), .rst(rst), .din(din), .din_valid(din_valid),
        .din_ready(rdy_l), .a(a_l), .a_valid(av_l), .busy(busy_l)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: queue of pending bits; ready whenever no bit is still pending
    always @(posedge clk) begin
        hs_seen = 1'b0;
        if (rst) begin
            q_msb.delete();
            q_lsb.delete();
            exp_a_m   = 1'b0;
            exp_a_l   = 1'b0;
            exp_valid = 1'b0;
        end else begin
            if (din_valid && q_msb.size() == 0) begin
                hs_seen = 1'b1;
                for (int i = W - 1; i >= 0; i--) q_msb.push_back(din[i]);
                for (int i = 0; i < W; i++) q_lsb.push_back(din[i]);
            end
            if (q_msb.size() > 0) begin
                exp_a_m   = q_msb.pop_front();
                exp_a_l   = q_lsb.pop_front();
                exp_valid = 1'b1;
            end else begin
                exp_a_m   = 1'b0;
                exp_a_l   = 1'b0;
                exp_valid = 1'b0;
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        if (chk_en) begin
            check("a_msb",     32'(a_m),    32'(exp_a_m));
            check("a_lsb",     32'(a_l),    32'(exp_a_l));
            check("avalid_m",  32'(av_m),   32'(exp_valid));
            check("avalid_l",  32'(av_l),   32'(exp_valid));
            check("busy_m",    32'(busy_m), 32'(exp_valid));
            check("busy_l",    32'(busy_l), 32'(exp_valid));
            check("ready_m",   32'(rdy_m),  32'(q_msb.size() == 0));
            check("ready_l",   32'(rdy_l),  32'(q_lsb.size() == 0));
            if (av_m) n_valid_m++;
            if (av_l) n_valid_l++;
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Present a word and hold it until the model sees the handshake
    task automatic send(input logic [W-1:0] w);
        din       = w;
        din_valid = 1'b1;
        for (int k = 0; k < 50; k++) begin
            @(posedge clk);
            #1;
            if (hs_seen) return;
        end
        check("send_timeout", 32'd0, 32'd1);
    endtask

    task automatic clear_counts();
        n_valid_m = 0;
        n_valid_l = 0;
    endtask

    task automatic check_counts(input string tag, input int exp);
        check({tag, "_cnt_m"}, 32'(n_valid_m), 32'(exp));
        check({tag, "_cnt_l"}, 32'(n_valid_l), 32'(exp));
    endtask

    initial begin
        rst       = 1'b1;
        din       = 8'hB4;
        din_valid = 1'b1;

        // Reset held 3 cycles with a word offered: nothing may be accepted
        @(posedge clk);
        #1;
        chk_en = 1'b1;
        tick(2);
        rst       = 1'b0;
        din_valid = 1'b0;
        check_counts("reset", 0);
        tick(1);
        check("ready_after_rst", 32'(rdy_m), 32'd1);

        // Single word
        clear_counts();
        send(8'hB4);
        din_valid = 1'b0;
        tick(10);
        check_counts("single", 8);

        // Back-to-back with valid held: second word taken in the last-bit cycle
        clear_counts();
        send(8'hB4);
        send(8'h2D);
        din_valid = 1'b0;
        tick(20);
        check_counts("b2b", 16);

        // One-hot word exercises the bit order of both instances
        clear_counts();
        send(8'h01);
        din_valid = 1'b0;
        tick(10);
        check_counts("onehot", 8);

        // Reset while the fourth bit is on a, then a clean word
        clear_counts();
        send(8'hFF);
        din_valid = 1'b0;
        tick(3);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        send(8'hB4);
        din_valid = 1'b0;
        tick(10);
        check_counts("midrst", 12);

        // Stall between words
        clear_counts();
        send(8'hB4);
        din_valid = 1'b0;
        tick(11);
        send(8'h2D);
        din_valid = 1'b0;
        tick(12);
        check_counts("stall", 16);

        // Random words with random gaps (zero gap keeps valid held)
        clear_counts();
        for (int n = 0; n < 8; n++) begin
            send(W'($urandom_range(0, 255)));
            if ($urandom_range(0, 1) == 1) begin
                din_valid = 1'b0;
                tick($urandom_range(1, 10));
            end
        end
        din_valid = 1'b0;
        tick(12);
        check_counts("random", 64);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // Bound on total run time
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule : tb_bit_stream_serializer
